// File: rtl/mem_pkg.sv
// Shared constants and clear-FSM state type for the scratch memory.
package mem_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_LANE_W = 8;
  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DEPTH  = 1024;
  localparam int unsigned DEF_N_RD   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/scratch_mem_if.sv
// Read/write/clear bus of the scratch memory; master drives requests, slave returns data.
interface scratch_mem_if
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LANE_W = DEF_LANE_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned N_RD   = DEF_N_RD
);

  logic [N_RD-1:0]          rd_en;
  logic [N_RD*ADDR_W-1:0]   rd_addr;
  logic [N_RD*DATA_W-1:0]   rd_data;
  logic [N_RD-1:0]          rd_valid;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W/LANE_W-1:0] wr_be;
  logic [DATA_W-1:0]        wr_data;
  logic                     clr_req;
  logic                     busy;
  logic                     err_oor;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data, clr_req,
    input  rd_data, rd_valid, busy, err_oor
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data, clr_req,
    output rd_data, rd_valid, busy, err_oor
  );

endinterface

// File: rtl/mem_lane_merge.sv
// Byte-lane merge: enabled lanes come from new_word, the rest from old_word.
module mem_lane_merge
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LANE_W = DEF_LANE_W
) (
  input  logic [DATA_W-1:0]        old_word,
  input  logic [DATA_W-1:0]        new_word,
  input  logic [DATA_W/LANE_W-1:0] be,
  output logic [DATA_W-1:0]        merged_c
);

  localparam int unsigned N_LANE = DATA_W / LANE_W;

  for (genvar k = 0; k < N_LANE; k++) begin : g_lane
    assign merged_c[k*LANE_W +: LANE_W] = be[k] ? new_word[k*LANE_W +: LANE_W]
                                                : old_word[k*LANE_W +: LANE_W];
  end

endmodule

// File: rtl/scratch_mem.sv
// Multi-read-port scratch RAM with lane-enabled writes and a one-word-per-cycle clear sweep.
// Define SCRATCH_MEM_FWD_EN to forward same-cycle write data to colliding reads.
module scratch_mem
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LANE_W = DEF_LANE_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned N_RD   = DEF_N_RD
) (
  input  logic          clk,
  input  logic          rst,
  scratch_mem_if.slave  bus
);

  clr_state_t        state_q, state_nxt;
  logic [ADDR_W-1:0] cnt_q, cnt_nxt;
  logic              sweep_done_c;
  logic              busy_q, err_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] old_word_c, merged_c;
  logic              accept_c, wr_oor_c, wr_fire_c;
  logic [N_RD-1:0]   rd_fire_c, rd_oor_c;

  // clr_req wins over any access presented in the same cycle
  assign accept_c   = (state_q == IDLE) && !bus.clr_req;
  assign wr_oor_c   = 32'(bus.wr_addr) >= DEPTH;
  assign wr_fire_c  = accept_c && bus.wr_en && !wr_oor_c;
  assign old_word_c = mem[bus.wr_addr];

  mem_lane_merge #(.DATA_W(DATA_W), .LANE_W(LANE_W)) u_merge (
    .old_word (old_word_c),
    .new_word (bus.wr_data),
    .be       (bus.wr_be),
    .merged_c (merged_c)
  );

  // Clear FSM next state
  always_comb begin
    state_nxt    = state_q;
    cnt_nxt      = cnt_q;
    sweep_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_nxt    = IDLE;
          cnt_nxt      = '0;
          sweep_done_c = 1'b1;
        end else begin
          cnt_nxt = cnt_q + ADDR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      busy_q  <= (state_nxt == CLEAR);
      if (sweep_done_c)
        err_q <= 1'b0;
      else if ((|(rd_fire_c & rd_oor_c)) || (accept_c && bus.wr_en && wr_oor_c))
        err_q <= 1'b1;
    end
  end

  // Array storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      mem[cnt_q] <= '0;
    else if (wr_fire_c)
      mem[bus.wr_addr] <= merged_c;
  end

  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] word_c;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    assign addr_c       = bus.rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_oor_c[i]  = 32'(addr_c) >= DEPTH;
    assign rd_fire_c[i] = accept_c && bus.rd_en[i];
`ifdef SCRATCH_MEM_FWD_EN
    assign word_c = (wr_fire_c && (addr_c == bus.wr_addr)) ? merged_c : mem[addr_c];
`else
    assign word_c = mem[addr_c];
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= rd_fire_c[i];
        if (rd_fire_c[i])
          data_q <= rd_oor_c[i] ? '0 : word_c;
      end
    end

    assign bus.rd_data[i*DATA_W +: DATA_W] = data_q;
    assign bus.rd_valid[i]                 = valid_q;
  end

  assign bus.busy    = busy_q;
  assign bus.err_oor = err_q;

endmodule

// File: doc/scratch_mem.md
SCRATCH_MEM -- requirements
Module: scratch_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning word width in bits; a multiple of LANE_W.
REQ-002 The block SHALL have parameter LANE_W, default 8, meaning byte-lane width for write enables.
REQ-003 The block SHALL have parameter ADDR_W, default 10, meaning address width.
REQ-004 The block SHALL have parameter DEPTH, default 1024, meaning number of words; DEPTH <= 2**ADDR_W.
REQ-005 The block SHALL have parameter N_RD, default 2, meaning number of independent read ports.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, reset; asynchronous and active-high.
REQ-008 The block SHALL have port rd_en, input, N_RD bits, per-port read request.
REQ-009 The block SHALL have port rd_addr, input, N_RD*ADDR_W bits, packed read addresses; port i is at [i*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port rd_data, output, N_RD*DATA_W bits, packed read data, using the same packing as rd_addr.
REQ-011 The block SHALL have port rd_valid, output, N_RD bits, per-port read data valid.
REQ-012 The block SHALL have port wr_en, input, 1 bit, write request.
REQ-013 The block SHALL have port wr_addr, input, ADDR_W bits, write address.
REQ-014 The block SHALL have port wr_be, input, DATA_W/LANE_W bits, lane enables; bit k covers data bits [k*LANE_W +: LANE_W].
REQ-015 The block SHALL have port wr_data, input, DATA_W bits, write data.
REQ-016 The block SHALL have port clr_req, input, 1 bit, a single-cycle request to zero the whole array.
REQ-017 The block SHALL have port busy, output, 1 bit, high while a clear sweep is in progress.
REQ-018 The block SHALL have port err_oor, output, 1 bit, sticky flag indicating an out-of-range access (address >= DEPTH).

Function
REQ-019 The block SHALL accept a read on port i when rd_en[i]=1 and busy=0, and SHALL present the data with rd_valid[i]=1 exactly one cycle later; all N_RD ports SHALL be served in the same cycle.
REQ-020 The block SHALL hold rd_data[i] at its last value while rd_valid[i]=0.
REQ-021 The block SHALL perform a write when wr_en=1 and busy=0, updating only the lanes whose wr_be bit is set; wr_be=0 SHALL leave the word unchanged.
REQ-022 The block SHALL ignore an out-of-range write, SHALL return 0 with rd_valid=1 for an out-of-range read, and SHALL set err_oor for either case.
REQ-023 The block SHALL run a clear state machine with states IDLE and CLEAR: on clr_req=1 in IDLE it enters CLEAR, writes zero to address 0..DEPTH-1 at one word per cycle, and returns to IDLE after address DEPTH-1; the sweep takes DEPTH cycles.
REQ-024 The block SHALL drive busy=1 in the cycle after clr_req is accepted through the last sweep cycle.
REQ-025 The block SHALL ignore rd_en and wr_en while busy=1, keeping rd_valid=0.
REQ-026 The block SHALL ignore clr_req while busy=1.
REQ-027 The block SHALL give clr_req priority over a wr_en or rd_en in the same cycle; that write and read are dropped.
REQ-028 The block SHALL clear err_oor when a clear sweep completes.
REQ-029 Multiple read ports addressing the same word in the same cycle SHALL all receive identical data.

Reset
REQ-030 On rst=1 the block SHALL immediately force rd_valid=0, rd_data=0, busy=0, err_oor=0, the FSM to IDLE, and the sweep counter to 0.
REQ-031 Array contents SHALL NOT be reset; a reset during CLEAR SHALL abort the sweep, leaving the array partially cleared.

Configuration
REQ-032 With SCRATCH_MEM_FWD_EN defined, a read and a write to the same address in the same cycle SHALL return the lane-merged new data: enabled lanes from wr_data, the rest from the old word.
REQ-033 Without SCRATCH_MEM_FWD_EN, the same collision SHALL return the old word (read-before-write).

Structure
REQ-034 Shared package mem_pkg SHALL hold the default parameter constants and the clear-FSM state typedef (IDLE, CLEAR).
REQ-035 The lane-merge function SHALL be one sub-module, mem_lane_merge, used by both the write path and the forwarding path.

Verification
REQ-036 The bench SHALL write 0x04030201 to 0x000 with wr_be=4'hF, then read it on ports 0 and 1 -> both rd_valid one cycle later, both rd_data 0x04030201.
REQ-037 The bench SHALL write 0xAABBCCDD with wr_be=4'b0101 over 0x11223344 at 0x100, then read 0x100 -> 0x11BB33DD.
REQ-038 The bench SHALL write 0xDEADBEEF to 0x005 with wr_be=4'hF and read 0x005 in the same cycle -> 0xDEADBEEF with SCRATCH_MEM_FWD_EN, the old value without it.
REQ-039 With DEPTH=1000, the bench SHALL read 0x3F0 -> rd_data 0, rd_valid 1, err_oor 1; a following write to 0x3F0 is ignored.
REQ-040 The bench SHALL pulse clr_req -> busy high for 1000 cycles; a rd_en during the sweep gives no rd_valid; afterwards every address reads 0 and err_oor=0.
REQ-041 The bench SHALL assert rst at sweep cycle 10 -> busy drops immediately; addresses 0-9 read 0 and address 500 keeps its prior value.
